// File: rtl/clock_controller.sv
`default_nettype none
// ============================================================================
//  Module      : clock_controller
//  Description : Run / halt / single-step sequencer for the gated system
//                clock. Produces the registered enable for the clock
//                generator so the core can run freely, stop on command or on
//                a breakpoint rising edge, or advance by exactly N cycles.
//                Clocked from the free-running (ungated) clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_controller #(
  parameter int COUNT_WIDTH = 16,
  parameter int CYCLE_WIDTH = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_run,
  input  logic                   i_halt,
  input  logic                   i_step,
  input  logic [COUNT_WIDTH-1:0] i_step_count,
  input  logic                   i_breakpoint,
  output logic                   o_enable,
  output logic                   o_halted,
  output logic [1:0]             o_state,
  output logic                   o_done,
  output logic [CYCLE_WIDTH-1:0] o_cycles
);

  // Encoding is visible on o_state, so the values are fixed.
  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CYCLE_WIDTH-1:0] CYCLE_ONE = {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state;
  state_t                 state_nxt;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [COUNT_WIDTH-1:0] remaining_nxt;
  logic                   done_nxt;
  logic                   enable_nxt;
  logic                   bp_q;
  logic                   bp_rise;

  // Only a fresh breakpoint assertion halts; a held level does not, so the
  // core can be stepped or run off a breakpoint that is still asserted.
  assign bp_rise = i_breakpoint & ~bp_q;

  // Next-state, remaining-step and completion decode, priority
  // halt > breakpoint edge > run > step.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;

    case (state)
      ST_HALTED: begin
        remaining_nxt = '0;
        if (!(i_halt || bp_rise)) begin
          if (i_run) begin
            state_nxt = ST_RUNNING;
          end else if (i_step) begin
            if (i_step_count != '0) begin
              state_nxt     = ST_STEPPING;
              remaining_nxt = i_step_count;
            end else begin
              // A zero-length step completes at once without enabling.
              done_nxt = 1'b1;
            end
          end
        end
      end

      ST_RUNNING: begin
        remaining_nxt = '0;
        if (i_halt || bp_rise) begin
          state_nxt = ST_HALTED;
        end
      end

      ST_STEPPING: begin
        // Breakpoint edges are deliberately ignored while stepping.
        if (i_halt) begin
          state_nxt     = ST_HALTED;
          remaining_nxt = '0;
        end else if (i_run) begin
          state_nxt     = ST_RUNNING;
          remaining_nxt = '0;
        end else if (remaining <= COUNT_ONE) begin
          // Last enabled cycle of the sequence; the <= also keeps the
          // counter from ever wrapping below zero.
          state_nxt     = ST_HALTED;
          remaining_nxt = '0;
          done_nxt      = 1'b1;
        end else begin
          remaining_nxt = remaining - COUNT_ONE;
        end
      end

      default: begin
        // Unreachable encoding: recover to a safe stopped state.
        state_nxt     = ST_HALTED;
        remaining_nxt = '0;
      end
    endcase

    enable_nxt = (state_nxt == ST_RUNNING) || (state_nxt == ST_STEPPING);
  end

  // State register plus all registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= ST_HALTED;
      remaining <= '0;
      bp_q      <= 1'b0;
      o_enable  <= 1'b0;
      o_halted  <= 1'b1;
      o_done    <= 1'b0;
      o_cycles  <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      bp_q      <= i_breakpoint;
      o_enable  <= enable_nxt;
      o_halted  <= (state_nxt == ST_HALTED);
      o_done    <= done_nxt;
      // Counts cycles in which the gated clock was enabled; wraps silently.
      if (o_enable) begin
        o_cycles <= o_cycles + CYCLE_ONE;
      end
    end
  end

  assign o_state = state;

endmodule
`default_nettype wire

// File: tb/tb_clock_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_controller
//  Description : Self-checking bench for clock_controller. Directed
//                sequences followed by randomized requests; a reference
//                model pushes expected outputs into a queue which a monitor
//                pops and compares every cycle. A second instance with a
//                4-bit cycle counter exercises counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        halt = 1'b0;
  logic        step = 1'b0;
  logic        bp = 1'b0;
  logic [15:0] cnt = '0;

  logic        en, hl, dn;
  logic [1:0]  st;
  logic [31:0] cy;
  logic        en4, hl4, dn4;
  logic [1:0]  st4;
  logic [3:0]  cy4;

  always #5 clk = ~clk;

  clock_controller #(.COUNT_WIDTH(16), .CYCLE_WIDTH(32)) dut (
    .i_clock(clk), .i_reset(rst), .i_run(run), .i_halt(halt), .i_step(step),
    .i_step_count(cnt), .i_breakpoint(bp),
    .o_enable(en), .o_halted(hl), .o_state(st), .o_done(dn), .o_cycles(cy)
  );

  clock_controller #(.COUNT_WIDTH(16), .CYCLE_WIDTH(4)) dut4 (
    .i_clock(clk), .i_reset(rst), .i_run(run), .i_halt(halt), .i_step(step),
    .i_step_count(cnt), .i_breakpoint(bp),
    .o_enable(en4), .o_halted(hl4), .o_state(st4), .o_done(dn4), .o_cycles(cy4)
  );

  typedef struct packed {
    logic        en;
    logic        halted;
    logic [1:0]  st;
    logic        done;
    logic [31:0] cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: mode 0=halted 1=running 2=stepping; m_left counts the
  // enabled cycles still owed to a step request.
  int          m_mode = 0;
  int unsigned m_left = 0;
  bit          m_bp_prev = 1'b0;
  bit          m_en = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_cyc = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply the current inputs to the model as one clock edge and queue the
  // outputs that should be visible after that edge.
  task automatic model_edge();
    bit   rise;
    exp_t e;
    rise = bp && !m_bp_prev;
    if (rst) begin
      m_mode = 0; m_left = 0; m_bp_prev = 1'b0;
      m_en = 1'b0; m_done = 1'b0; m_cyc = '0;
    end else begin
      if (m_en) m_cyc = m_cyc + 32'd1;
      m_bp_prev = bp;
      m_done    = 1'b0;
      if (m_mode == 0) begin
        if (!halt && !rise) begin
          if (run) begin
            m_mode = 1;
          end else if (step) begin
            if (cnt == 16'd0) m_done = 1'b1;
            else begin
              m_mode = 2;
              m_left = cnt;
            end
          end
        end
      end else if (m_mode == 1) begin
        if (halt || rise) m_mode = 0;
      end else begin
        if (halt) begin
          m_mode = 0; m_left = 0;
        end else if (run) begin
          m_mode = 1; m_left = 0;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_mode = 0;
            m_done = 1'b1;
          end
        end
      end
      m_en = (m_mode != 0);
    end
    e.en     = m_en;
    e.halted = (m_mode == 0);
    e.st     = 2'(m_mode);
    e.done   = m_done;
    e.cyc    = m_cyc;
    q.push_back(e);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    run = 1'b0; halt = 1'b0; step = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_step(input logic [15:0] n);
    step = 1'b1; cnt = n; tick();
  endtask

  // Monitor: compare both instances against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("enable", {31'd0, en}, {31'd0, e.en});
      chk("halted", {31'd0, hl}, {31'd0, e.halted});
      chk("state",  {30'd0, st}, {30'd0, e.st});
      chk("done",   {31'd0, dn}, {31'd0, e.done});
      chk("cycles", cy, e.cyc);
      chk("enable4", {31'd0, en4}, {31'd0, e.en});
      chk("state4",  {30'd0, st4}, {30'd0, e.st});
      chk("done4",   {31'd0, dn4}, {31'd0, e.done});
      chk("cycles4", {28'd0, cy4}, {28'd0, e.cyc[3:0]});
    end
  end

  initial begin
    // Reset and idle.
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    idle(5);
    chk("reset_cycles", cy, 32'd0);

    // Step of five cycles.
    do_step(16'd5);
    idle(8);
    chk("step5_cycles", cy, 32'd5);

    // Free run with an ignored step request, then halt after 11 enabled edges.
    run = 1'b1; tick();
    idle(5);
    do_step(16'd7);
    idle(4);
    halt = 1'b1; tick();
    idle(3);
    chk("run_cycles", cy, 32'd16);

    // Breakpoint edge halts; step and run then proceed with breakpoint held.
    run = 1'b1; tick();
    idle(3);
    bp = 1'b1; tick();
    idle(3);
    do_step(16'd3);
    idle(5);
    run = 1'b1; tick();
    idle(4);
    halt = 1'b1; tick();
    bp = 1'b0;
    idle(2);

    // Long step cut short by halt, then by reset.
    do_step(16'd100);
    idle(39);
    halt = 1'b1; tick();
    idle(3);
    do_step(16'd100);
    idle(39);
    rst = 1'b1; tick();
    idle(3);
    chk("abort_reset_cycles", cy, 32'd0);

    // Simultaneous run+halt, zero-length step, 4-bit counter wrap.
    run = 1'b1; halt = 1'b1; tick();
    idle(3);
    do_step(16'd0);
    idle(3);
    rst = 1'b1; tick();
    run = 1'b1; tick();
    idle(19);
    halt = 1'b1; tick();
    idle(2);
    chk("wrap4_cycles", {28'd0, cy4}, 32'd4);

    // Maximum step count, halted early.
    do_step(16'hFFFF);
    idle(10);
    halt = 1'b1; tick();
    idle(2);

    // Randomized requests, possibly simultaneous.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      run  = ($urandom_range(0, 19) == 0);
      halt = ($urandom_range(0, 24) == 0);
      step = ($urandom_range(0, 9) == 0);
      cnt  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      if ($urandom_range(0, 19) == 0) bp = ~bp;
      tick();
    end

    idle(2);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
